// File: rtl/led_mem_pkg.sv
// Shared constants, FSM state type and the fill pattern for the LED memory demo.
package led_mem_pkg;

  localparam int DEPTH = 16;
  localparam int AW    = 4;
  localparam int DW    = 16;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WRITE = 2'd1,
    READ  = 2'd2
  } state_e;

  // Thermometer word for address a: 2^(a+1)-1, so a=0 -> 0x0001 and a=15 -> 0xFFFF.
  function automatic logic [DW-1:0] pat(input logic [AW-1:0] a);
    return {DW{1'b1}} >> (DW - 1 - int'(a));
  endfunction

endpackage

// File: rtl/led_mem_clk_div.sv
// Behavioural stand-in for the vendor clock wizard: divide by two and
// raise locked after 16 output rising edges. It has no reset input, so the
// registers carry power-up values instead.
module clk_div (
  input  logic clk_in1,
  output logic clk_out1,
  output logic locked
);

  logic       clk_q    = 1'b0;
  logic [4:0] lock_cnt_q = 5'd0;

  // Toggle on every input edge to halve the frequency.
  always_ff @(posedge clk_in1) begin
    clk_q <= ~clk_q;
  end

  // Count output edges until bit 4 sets, then freeze so locked stays high.
  always_ff @(posedge clk_q) begin
    if (!lock_cnt_q[4]) lock_cnt_q <= lock_cnt_q + 5'd1;
  end

  assign clk_out1 = clk_q;
  assign locked   = lock_cnt_q[4];

endmodule

// File: rtl/led_mem_ram.sv
// Inferred 16x16 single-port RAM with a registered read port (one cycle latency).
// Contents are intentionally not reset; only a write phase defines them.
module led_mem
  import led_mem_pkg::*;
(
  input  logic          clka,
  input  logic          ena,
  input  logic          wea,
  input  logic [AW-1:0] addra,
  input  logic [DW-1:0] dina,
  output logic [DW-1:0] douta
);

  logic [DW-1:0] mem_q [DEPTH];
  logic [DW-1:0] douta_q;

  // Synchronous write and read-first registered read while enabled.
  always_ff @(posedge clka) begin
    if (ena) begin
      if (wea) mem_q[addra] <= dina;
      douta_q <= mem_q[addra];
    end
  end

  assign douta = douta_q;

endmodule

// File: rtl/led_memory_top.sv
// LED memory demonstrator: on a button rising edge, fill the RAM with a
// thermometer pattern, read it back in order and show the last word on the LEDs.
module led_memory_top
  import led_mem_pkg::*;
(
  input  logic          clk,
  input  logic          rst,
  input  logic          button,
  output logic [DW-1:0] led
);

  logic          clk_g;
  logic          locked;

  state_e        state_q, state_d;
  logic [AW-1:0] addr_q, addr_d;
  logic          btn_q;
  logic          rd_vld_q;
  logic [DW-1:0] led_q;

  logic          ena, wea;
  logic [AW-1:0] addra;
  logic [DW-1:0] dina, douta;
  logic          start;

  clk_div u_clk_div (
    .clk_in1  (clk),
    .clk_out1 (clk_g),
    .locked   (locked)
  );

  led_mem u_led_mem (
    .clka  (clk_g),
    .ena   (ena),
    .wea   (wea),
    .addra (addra),
    .dina  (dina),
    .douta (douta)
  );

  // A run is only accepted once the core clock is stable.
  assign start = button & ~btn_q & locked;

  // Next-state and RAM port drive; the address counter wraps 15->0 at each phase end.
  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    ena     = 1'b0;
    wea     = 1'b0;
    addra   = addr_q;
    dina    = '0;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          state_d = WRITE;
          addr_d  = '0;
        end
      end
      WRITE: begin
        ena    = 1'b1;
        wea    = 1'b1;
        dina   = pat(addr_q);
        addr_d = addr_q + 1'b1;
        if (addr_q == AW'(DEPTH - 1)) state_d = READ;
      end
      READ: begin
        ena    = 1'b1;
        addr_d = addr_q + 1'b1;
        if (addr_q == AW'(DEPTH - 1)) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // State, counter, edge register and LED register; led captures douta one
  // cycle after each read cycle.
  always_ff @(posedge clk_g or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      addr_q   <= '0;
      btn_q    <= 1'b0;
      rd_vld_q <= 1'b0;
      led_q    <= '0;
    end else begin
      state_q  <= state_d;
      addr_q   <= addr_d;
      btn_q    <= button;
      rd_vld_q <= (state_q == READ);
      if (rd_vld_q) led_q <= douta;
    end
  end

  assign led = led_q;

endmodule

// File: tb/tb_led_memory_top.sv
// Bench for led_memory_top: a run-index reference model predicts the RAM port
// and LED values every core-clock cycle; directed and random button/reset
// sequences exercise it.
module tb_led_memory_top;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        button = 1'b0;
  logic [15:0] led;

  int n_vec  = 0;
  int n_fail = 0;
  int en_cnt = 0;

  // Reference model state: run_idx -1 = idle, 0..15 write, 16..31 read.
  int          run_idx  = -1;
  logic        btn_prev = 1'b0;
  logic        lock_ok  = 1'b0;
  int          pos_edges = 0;
  logic [15:0] mem_m [16];
  logic [15:0] douta_m = '0;
  logic        dv_m    = 1'b0;
  int          rd_a_m  = 0;
  logic [15:0] led_m   = '0;

  led_memory_top dut (
    .clk    (clk),
    .rst    (rst),
    .button (button),
    .led    (led)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: advance one core cycle from the spec's rules.
  always @(posedge dut.clk_g or posedge rst) begin
    if (rst) begin
      run_idx  = -1;
      btn_prev = 1'b0;
      dv_m     = 1'b0;
      led_m    = '0;
    end else begin
      if (run_idx >= 0 && run_idx < 16) mem_m[run_idx] = 16'((32'd1 << (run_idx + 1)) - 1);
      if (dv_m) led_m = douta_m;
      if (run_idx >= 16) begin
        rd_a_m  = run_idx - 16;
        douta_m = mem_m[rd_a_m];
        dv_m    = 1'b1;
      end else begin
        dv_m = 1'b0;
      end
      if (run_idx < 0) run_idx = (button && !btn_prev && lock_ok) ? 0 : -1;
      else             run_idx = (run_idx == 31) ? -1 : run_idx + 1;
      btn_prev = button;
    end
  end

  // Compare process: check every observable signal mid-cycle.
  always @(negedge dut.clk_g) begin
    pos_edges++;
    lock_ok = (pos_edges >= 16);
    check("locked", 32'(dut.locked), 32'(lock_ok));
    check("ena", 32'(dut.u_led_mem.ena), 32'(run_idx >= 0));
    check("wea", 32'(dut.u_led_mem.wea), 32'(run_idx >= 0 && run_idx < 16));
    if (run_idx >= 0) check("addra", 32'(dut.u_led_mem.addra), 32'(run_idx % 16));
    if (run_idx >= 0 && run_idx < 16)
      check("dina", 32'(dut.u_led_mem.dina), (32'd1 << (run_idx + 1)) - 1);
    if (dv_m) begin
      check("douta", 32'(dut.u_led_mem.douta), 32'(douta_m));
      case (rd_a_m)
        0:  check("douta_k0",  32'(dut.u_led_mem.douta), 32'h0001);
        7:  check("douta_k7",  32'(dut.u_led_mem.douta), 32'h00FF);
        14: check("douta_k14", 32'(dut.u_led_mem.douta), 32'h7FFF);
        15: check("douta_k15", 32'(dut.u_led_mem.douta), 32'hFFFF);
        default: ;
      endcase
    end
    check("led", 32'(led), 32'(led_m));
    if (dut.u_led_mem.ena) en_cnt++;
  end

  task automatic cycles(input int n);
    repeat (n) @(posedge dut.clk_g);
    #1;
  endtask

  task automatic press(input int len);
    button = 1'b1;
    cycles(len);
    button = 1'b0;
  endtask

  initial begin
    // Reset, then idle long enough for locked to rise.
    cycles(3);
    rst = 1'b0;
    cycles(25);
    @(negedge dut.clk_g);
    check("idle_ena_lit", 32'(dut.u_led_mem.ena), 32'h0);
    check("idle_led_lit", 32'(led), 32'h0000);
    check("idle_locked_lit", 32'(dut.locked), 32'h1);

    // Single pulse: one full run.
    cycles(1);
    en_cnt = 0;
    press(1);
    cycles(40);
    check("run1_led_lit", 32'(led), 32'hFFFF);
    check("run1_en_cnt", 32'(en_cnt), 32'd32);

    // Held button for 40 cycles: still one run.
    en_cnt = 0;
    press(40);
    cycles(10);
    check("hold_en_cnt", 32'(en_cnt), 32'd32);
    check("hold_led_lit", 32'(led), 32'hFFFF);

    // Extra pulses during WRITE and READ are ignored.
    en_cnt = 0;
    press(1);
    cycles(4);
    press(1);
    cycles(14);
    press(2);
    cycles(30);
    check("busy_en_cnt", 32'(en_cnt), 32'd32);

    // Reset mid-READ clears ena and led at once, then a fresh run repeats the data.
    press(1);
    cycles(20);
    #2 rst = 1'b1;
    #1;
    check("rst_ena_lit", 32'(dut.u_led_mem.ena), 32'h0);
    check("rst_led_lit", 32'(led), 32'h0000);
    cycles(2);
    rst = 1'b0;
    cycles(2);
    en_cnt = 0;
    press(1);
    cycles(40);
    check("rerun_led_lit", 32'(led), 32'hFFFF);
    check("rerun_en_cnt", 32'(en_cnt), 32'd32);

    // Random button activity with occasional resets.
    for (int i = 0; i < 40; i++) begin
      button = 1'($urandom_range(0, 1));
      cycles($urandom_range(1, 12));
      if ($urandom_range(0, 9) == 0) begin
        #($urandom_range(1, 8)) rst = 1'b1;
        cycles($urandom_range(1, 3));
        rst = 1'b0;
      end
    end
    button = 1'b0;
    cycles(40);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
